// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (FWD/ADD/AND/OR/SUB) complete on the accept edge.
// MUL runs a shift-add multiplier for WIDTH cycles. SLL/SRA shift one
// bit per cycle. Results and flags are registered and held until the
// consumer takes them.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   data1_i      operand A
//   data2_i      operand B; low log2(WIDTH) bits are the shift amount
//   select_i     opcode: 000 FWD, 001 ADD, 010 AND, 011 OR,
//                        100 SUB, 101 MUL, 110 SLL, 111 SRA
//   in_valid_i   operands/opcode valid
//   in_ready_o   block can accept an operation
//   result_o     registered result
//   zero_o       result equals zero
//   carry_o      carry / borrow / last shift-out / multiply overflow
//   overflow_o   two's-complement overflow (ADD/SUB only)
//   out_valid_o  result and flags valid
//   out_ready_i  consumer accepts result
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       select_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned CNT_W = SHW + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [PW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             live_q;

    logic             accept_c;
    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   sub_c;
    logic             add_ovf_c;
    logic             sub_ovf_c;
    logic [SHW-1:0]   shamt_c;

    logic [WIDTH:0]   mul_sum_c;
    logic [PW-1:0]    mul_next_c;
    logic [WIDTH-1:0] sll_next_c;
    logic [WIDTH-1:0] sra_next_c;

    logic             fin_c;
    logic [WIDTH-1:0] fin_res_c;
    logic             fin_carry_c;
    logic             fin_ovf_c;

    // live_q holds in_ready low until the first edge after reset release
    assign in_ready_o = live_q &&
                        ((state_q == IDLE) || ((state_q == HOLD) && out_ready_i));
    assign accept_c   = in_valid_i && in_ready_o;

    // Single-cycle arithmetic on the live operands
    assign add_c     = {1'b0, data1_i} + {1'b0, data2_i};
    assign sub_c     = {1'b0, data1_i} - {1'b0, data2_i};
    assign add_ovf_c = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                       (add_c[WIDTH-1] != data1_i[WIDTH-1]);
    assign sub_ovf_c = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                       (sub_c[WIDTH-1] != data1_i[WIDTH-1]);
    assign shamt_c   = data2_i[SHW-1:0];

    // One iteration step. For MUL, work_q = {partial high, remaining multiplier}
    // and the low bit selects whether the multiplicand is added before shifting.
    assign mul_sum_c  = {1'b0, work_q[PW-1:WIDTH]} +
                        (work_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next_c = {mul_sum_c, work_q[WIDTH-1:1]};
    assign sll_next_c = {work_q[WIDTH-2:0], 1'b0};
    assign sra_next_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        fin_c       = 1'b0;
        fin_res_c   = '0;
        fin_carry_c = 1'b0;
        fin_ovf_c   = 1'b0;

        unique case (state_q)
            ITER: begin
                cnt_d = cnt_q - CNT_W'(1);
                unique case (op_q)
                    OP_SLL: begin
                        work_d      = {work_q[PW-1:WIDTH], sll_next_c};
                        fin_res_c   = sll_next_c;
                        fin_carry_c = work_q[WIDTH-1];
                    end
                    OP_SRA: begin
                        work_d      = {work_q[PW-1:WIDTH], sra_next_c};
                        fin_res_c   = sra_next_c;
                        fin_carry_c = work_q[0];
                    end
                    default: begin
                        work_d      = mul_next_c;
                        fin_res_c   = mul_next_c[WIDTH-1:0];
                        fin_carry_c = |mul_next_c[PW-1:WIDTH];
                    end
                endcase
                fin_c = (cnt_q == CNT_W'(1));
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase

        // Accept may coincide with retiring a HOLD result
        if (accept_c) begin
            op_d    = select_i;
            mcand_d = data1_i;
            cnt_d   = '0;
            unique case (select_i)
                OP_FWD: begin
                    fin_c     = 1'b1;
                    fin_res_c = data2_i;
                end
                OP_ADD: begin
                    fin_c       = 1'b1;
                    fin_res_c   = add_c[WIDTH-1:0];
                    fin_carry_c = add_c[WIDTH];
                    fin_ovf_c   = add_ovf_c;
                end
                OP_AND: begin
                    fin_c     = 1'b1;
                    fin_res_c = data1_i & data2_i;
                end
                OP_OR: begin
                    fin_c     = 1'b1;
                    fin_res_c = data1_i | data2_i;
                end
                OP_SUB: begin
                    fin_c       = 1'b1;
                    fin_res_c   = sub_c[WIDTH-1:0];
                    fin_carry_c = sub_c[WIDTH];
                    fin_ovf_c   = sub_ovf_c;
                end
                OP_MUL: begin
                    if (MUL_EN != 0) begin
                        state_d     = ITER;
                        out_valid_d = 1'b0;
                        cnt_d       = CNT_W'(WIDTH);
                        work_d      = {{WIDTH{1'b0}}, data2_i};
                    end else begin
                        fin_c = 1'b1;
                    end
                end
                default: begin
                    // SLL / SRA; a zero amount completes immediately
                    if (shamt_c == '0) begin
                        fin_c     = 1'b1;
                        fin_res_c = data1_i;
                    end else begin
                        state_d     = ITER;
                        out_valid_d = 1'b0;
                        cnt_d       = CNT_W'(shamt_c);
                        work_d      = {{WIDTH{1'b0}}, data1_i};
                    end
                end
            endcase
        end

        // The only place the visible result registers are loaded
        if (fin_c) begin
            state_d     = HOLD;
            result_d    = fin_res_c;
            zero_d      = (fin_res_c == '0);
            carry_d     = fin_carry_c;
            ovf_d       = fin_ovf_c;
            out_valid_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            live_q      <= 1'b1;
        end
    end

    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign carry_o     = carry_q;
    assign overflow_o  = ovf_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, MUL_EN=1).
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic [W-1:0] data1     = '0;
    logic [W-1:0] data2     = '0;
    logic [2:0]   select    = '0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .data1_i     (data1),
        .data2_i     (data2),
        .select_i    (select),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_o    (result),
        .zero_o      (zero),
        .carry_o     (carry),
        .overflow_o  (overflow),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    // Reference: result/flags from plain integer arithmetic, latency in edges
    // counted from (and including) the accept edge.
    function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, output logic [7:0] r,
                                  output logic c, output logic v, output int lat);
        int ua, ub, sa, sb, s, n, t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = ub % 8;
        c = 1'b0; v = 1'b0; lat = 1; r = 8'h00;
        case (op)
            3'd0: r = b;
            3'd1: begin
                s = ua + ub; r = 8'(s); c = (s > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin
                s = ua - ub; r = 8'(s); c = (ua < ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3'd5: begin
                s = ua * ub; r = 8'(s); c = (s > 255); lat = W + 1;
            end
            3'd6: begin
                if (n == 0) r = a;
                else begin
                    r = 8'(ua << n); t = ua >> (8 - n); c = t[0]; lat = n + 1;
                end
            end
            default: begin
                if (n == 0) r = a;
                else begin
                    r = 8'(sa >>> n); t = ua >> (n - 1); c = t[0]; lat = n + 1;
                end
            end
        endcase
    endfunction

    // Drive one operation with out_ready=1 and observe its outcome.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic c, output logic v,
                          output logic z, output int lat, output int busy);
        int guard;
        @(negedge clk);
        select = op; data1 = a; data2 = b; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 1;
        busy = 0;
        #1;
        in_valid = 1'b0;
        data1 = 8'($urandom);
        data2 = 8'($urandom);
        select = 3'($urandom);
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        r = result; c = carry; v = overflow; z = zero;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({result, zero, carry, overflow, out_valid, in_ready} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h z=%b c=%b v=%b ov=%b ir=%b, want all zero",
                     result, zero, carry, overflow, out_valid, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 0 before first edge", in_ready);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_edge: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [12];
        logic [7:0]  t_a   [12];
        logic [7:0]  t_b   [12];
        logic [10:0] t_exp [12];
        int          t_lat [12];
        logic [7:0]  r;
        logic        c, v, z;
        int          lat, busy;
        t_op  = '{3'd1, 3'd1, 3'd4, 3'd4, 3'd5, 3'd5, 3'd7, 3'd6, 3'd0, 3'd2, 3'd6, 3'd5};
        t_a   = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h10, 8'h0F, 8'h94, 8'h81, 8'h12, 8'hF0, 8'h81, 8'hFF};
        t_b   = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h11, 8'h03, 8'h03, 8'h00, 8'hA5, 8'h3C, 8'h09, 8'hFF};
        t_exp = '{{8'h80, 3'b010}, {8'h00, 3'b101}, {8'hFE, 3'b100}, {8'h7F, 3'b010},
                  {8'h10, 3'b100}, {8'h2D, 3'b000}, {8'hF2, 3'b100}, {8'h81, 3'b000},
                  {8'hA5, 3'b000}, {8'h30, 3'b000}, {8'h02, 3'b100}, {8'h01, 3'b100}};
        t_lat = '{1, 1, 1, 1, 9, 9, 4, 1, 1, 1, 2, 9};
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r, c, v, z, lat, busy);
            checks++;
            if ({r, c, v, z} !== t_exp[i]) begin
                failures++;
                $display("FAIL directed_value[%0d]: got res=%h c=%b v=%b z=%b, want {res,c,v,z}=%h",
                         i, r, c, v, z, t_exp[i]);
            end
            checks++;
            if (lat != t_lat[i]) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d edges want %0d", i, lat, t_lat[i]);
            end
            checks++;
            if (busy != t_lat[i] - 1) begin
                failures++;
                $display("FAIL directed_busy[%0d]: in_ready low %0d cycles want %0d",
                         i, busy, t_lat[i] - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op [6];
        logic [7:0] a  [6];
        logic [7:0] b  [6];
        logic [7:0] er [6];
        logic       ec [6];
        logic       ev [6];
        logic       ez [6];
        int         el;
        for (int i = 0; i < 6; i++) begin
            op[i] = 3'($urandom_range(0, 4));
            a[i]  = 8'($urandom);
            b[i]  = 8'($urandom);
            model(op[i], a[i], b[i], er[i], ec[i], ev[i], el);
            ez[i] = (er[i] == 8'h00);
        end
        @(negedge clk);
        out_ready = 1'b1;
        select = op[0]; data1 = a[0]; data2 = b[0]; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, result, carry, overflow, zero} !== {1'b1, er[i], ec[i], ev[i], ez[i]}) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got ov=%b res=%h c=%b v=%b z=%b want ov=1 res=%h c=%b v=%b z=%b",
                         i, out_valid, result, carry, overflow, zero, er[i], ec[i], ev[i], ez[i]);
            end
            if (i < 5) begin
                select = op[i+1]; data1 = a[i+1]; data2 = b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a1, b1, a2, b2, r1, r2;
        logic       c1, v1, c2, v2, z1, z2;
        int         l;
        a1 = 8'($urandom); b1 = 8'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom);
        model(3'd2, a1, b1, r1, c1, v1, l);
        model(3'd4, a2, b2, r2, c2, v2, l);
        z1 = (r1 == 8'h00);
        z2 = (r2 == 8'h00);
        @(negedge clk);
        out_ready = 1'b0;
        select = 3'd2; data1 = a1; data2 = b1; in_valid = 1'b1;
        @(negedge clk);
        select = 3'd4; data1 = a2; data2 = b2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, result, carry, overflow, zero} !== {1'b1, 1'b0, r1, c1, v1, z1}) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b res=%h c=%b v=%b z=%b want ov=1 ir=0 res=%h c=%b v=%b z=%b",
                         i, out_valid, in_ready, result, carry, overflow, zero, r1, c1, v1, z1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, carry, overflow, zero} !== {1'b1, r2, c2, v2, z2}) begin
            failures++;
            $display("FAIL backpressure_next: got ov=%b res=%h c=%b v=%b z=%b want ov=1 res=%h c=%b v=%b z=%b",
                     out_valid, result, carry, overflow, zero, r2, c2, v2, z2);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] a, b, r, er;
        logic       c, v, z, ec, ev, ez;
        int         lat, busy, el;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            model(op, a, b, er, ec, ev, el);
            ez = (er == 8'h00);
            run_op(op, a, b, r, c, v, z, lat, busy);
            checks++;
            if ({r, c, v, z} !== {er, ec, ev, ez}) begin
                failures++;
                $display("FAIL random_value[%0d] op=%0d a=%h b=%h: got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                         i, op, a, b, r, c, v, z, er, ec, ev, ez);
            end
            checks++;
            if (lat != el) begin
                failures++;
                $display("FAIL random_latency[%0d] op=%0d b=%h: got %0d want %0d", i, op, b, lat, el);
            end
        end
    endtask

    task automatic test_reset_mid_iter();
        logic [7:0] r;
        logic       c, v, z;
        int         lat, busy, stale;
        run_op(3'd1, 8'h12, 8'h34, r, c, v, z, lat, busy);
        checks++;
        if (r !== 8'h46) begin
            failures++;
            $display("FAIL mid_reset_setup: got %h want 46", r);
        end
        @(negedge clk);
        select = 3'd5; data1 = 8'h37; data2 = 8'h5B; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, in_ready} !== {1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_immediate: got ov=%b res=%h ir=%b want ov=0 res=00 ir=0",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready: got %b want 1", in_ready);
        end
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL mid_reset_stale: out_valid high on %0d cycles want 0", stale);
        end
        run_op(3'd4, 8'h20, 8'h21, r, c, v, z, lat, busy);
        checks++;
        if ({r, c, v, z, lat} !== {8'hFF, 1'b1, 1'b0, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL mid_reset_recover: got res=%h c=%b v=%b z=%b lat=%0d want res=ff c=1 v=0 z=0 lat=1",
                     r, c, v, z, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_iter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a power of two and at least 4.
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiplier for SELECT=101.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 DATA1  input  WIDTH  operand A.
REQ-006 DATA2  input  WIDTH  operand B; bits [log2(WIDTH)-1:0] are the shift amount for shifts.
REQ-007 SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 SUB, 101 MUL, 110 SLL, 111 SRA.
REQ-008 IN_VALID  input  1  operands and opcode valid.
REQ-009 IN_READY  output  1  block can accept an operation.
REQ-010 RESULT  output  WIDTH  registered result.
REQ-011 ZERO  output  1  RESULT equals zero.
REQ-012 CARRY  output  1  carry/borrow/shift-out/multiply-overflow flag.
REQ-013 OVERFLOW  output  1  signed overflow flag.
REQ-014 OUT_VALID  output  1  RESULT and flags valid.
REQ-015 OUT_READY  input  1  consumer accepts result.

Function
REQ-016 FSM states SHALL be IDLE, ITER, HOLD.
REQ-017 Accept SHALL occur on a rising edge with IN_VALID=1 and IN_READY=1; DATA1, DATA2, SELECT SHALL be captured then and later input changes ignored.
REQ-018 IN_READY SHALL equal 1 in IDLE, equal OUT_READY in HOLD, 0 in ITER.
REQ-019 FWD, ADD, AND, OR, SUB: accept -> HOLD; OUT_VALID SHALL rise on the edge after accept (latency 1).
REQ-020 FWD SHALL give DATA2; AND/OR bitwise; ADD DATA1+DATA2 mod 2^WIDTH; SUB DATA1-DATA2 mod 2^WIDTH.
REQ-021 ADD: CARRY = unsigned carry-out; OVERFLOW = two's-complement overflow.
REQ-022 SUB: CARRY = 1 iff DATA1 < DATA2 unsigned (borrow); OVERFLOW = two's-complement overflow.
REQ-023 MUL (MUL_EN=1): accept -> ITER, one shift-add step per cycle for WIDTH cycles, then HOLD; OUT_VALID after WIDTH+1 edges post-accept.
REQ-024 MUL RESULT = low WIDTH bits of unsigned product; CARRY = 1 iff high WIDTH bits nonzero; OVERFLOW = 0.
REQ-025 MUL with MUL_EN=0: latency 1, RESULT=0, CARRY=0, OVERFLOW=0, ZERO=1.
REQ-026 SLL/SRA: amount N = DATA2[log2(WIDTH)-1:0]; one bit per cycle in ITER; OUT_VALID after N+1 edges post-accept.
REQ-027 N=0 SHALL go directly to HOLD with RESULT=DATA1 and CARRY=0 (latency 1).
REQ-028 SLL fills zeros; SRA replicates the sign bit; CARRY = last bit shifted out; OVERFLOW = 0.
REQ-029 AND, OR, FWD: CARRY=0, OVERFLOW=0.
REQ-030 ZERO SHALL be computed for every opcode from final RESULT.
REQ-031 In HOLD, RESULT, flags, OUT_VALID SHALL stay stable until an edge with OUT_READY=1.
REQ-032 HOLD with OUT_READY=1 and IN_VALID=0 -> IDLE, OUT_VALID=0 next cycle.
REQ-033 HOLD with OUT_READY=1 and IN_VALID=1 SHALL retire and accept on the same edge (back-to-back, no bubble for latency-1 ops).
REQ-034 RESULT/flags SHALL change only on the edge that loads HOLD; intermediate ITER values not visible on outputs.
REQ-035 OUT_VALID SHALL be 0 in IDLE and ITER.

Reset
REQ-036 RESET_N=0 SHALL immediately force state IDLE, RESULT=0, ZERO=0, CARRY=0, OVERFLOW=0, OUT_VALID=0, iteration counter 0.
REQ-037 IN_READY SHALL be 0 while RESET_N=0 and 1 from the first edge after release.
REQ-038 Reset during ITER or HOLD SHALL discard the operation; no OUT_VALID for it after release.

Verification (WIDTH=8, MUL_EN=1)
REQ-039 ADD 0x7F+0x01 -> after 1 edge RESULT=0x80, OVERFLOW=1, CARRY=0, ZERO=0; ADD 0xFF+0x01 -> 0x00, CARRY=1, ZERO=1.
REQ-040 SUB 0x05-0x07 -> RESULT=0xFE, CARRY=1, OVERFLOW=0; SUB 0x80-0x01 -> 0x7F, OVERFLOW=1.
REQ-041 MUL 0x10*0x11 -> IN_READY=0 for 8 cycles, OUT_VALID on 9th edge, RESULT=0x10, CARRY=1; MUL 0x0F*0x03 -> 0x2D, CARRY=0.
REQ-042 SRA 0x94 by 3 -> OUT_VALID on 4th edge, RESULT=0xF2, CARRY=1; SLL 0x81 by 0 -> latency 1, RESULT=0x81, CARRY=0.
REQ-043 Backpressure: OUT_READY=0 for 5 cycles -> RESULT stable, IN_READY=0, pending IN_VALID not accepted; then OUT_READY=1 with IN_VALID=1 -> back-to-back accept, next OUT_VALID one edge later.
REQ-044 RESET_N low in 4th ITER cycle of MUL -> OUT_VALID=0, RESULT=0 immediately; after release IN_READY=1, no stale result emitted.
